// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field positions
// and the write masks used by MTC0.
package cp0_pkg;

    // Register numbers as seen by MFC0/MTC0
    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;
    localparam logic [4:0] CP0_REG_PRID     = 5'd15;
    localparam logic [4:0] CP0_REG_CONFIG   = 5'd16;

    // Exception codes
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] EXC_TR   = 5'd13;

    // Status fields
    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_IM_HI = 15;
    localparam int STATUS_BEV = 22;

    // Cause fields
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_TI     = 30;
    localparam int CAUSE_BD     = 31;

    // Bits that MTC0 may change
    localparam logic [31:0] STATUS_WMASK = 32'h0040_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    // True for exception codes that report a faulting address
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with a clock prescaler and a sticky timer-interrupt flag.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic          ti_q, ti_d;
    logic          inc;

    // Count advances on the cycle the prescaler wraps
    assign inc = (presc_q == PRESC_LAST);

    // Next-state: a Count write restarts the prescale period, a Compare write beats a match
    always_comb begin
        presc_d   = inc ? '0 : presc_q + 1'b1;
        count_d   = inc ? count_q + 32'd1 : count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (inc && (count_q == compare_q)) begin
            ti_d = 1'b1;
        end
        if (count_we_i) begin
            count_d = wdata_i;
            presc_d = '0;
        end
        if (compare_we_i) begin
            compare_d = wdata_i;
            ti_d      = 1'b0;
        end
    end

    // Timer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_ctrl.sv
// CP0 register file and exception/ERET commit controller beside the MEM stage.
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_HW_INT = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] PRID_VAL   = 32'h0000_4220,
    parameter logic [31:0] CONFIG_VAL = 32'h0000_8000,
    parameter logic [31:0] STATUS_RST = 32'h0040_FF00,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [4:0]            raddr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o,
    input  logic [NUM_HW_INT-1:0] int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic                  eret_i,
    input  logic [31:0]           pc_i,
    input  logic                  in_ds_i,
    input  logic [31:0]           badvaddr_i,
    input  logic                  mem_valid_i,
    output logic                  int_req_o,
    output logic                  flush_o,
    output logic [31:0]           new_pc_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic                  timer_int_o
);

    logic [31:0]           status_q, status_d;
    logic [31:0]           epc_q, epc_d;
    logic [31:0]           badvaddr_q, badvaddr_d;
    logic                  bd_q, bd_d;
    logic [4:0]            exccode_q, exccode_d;
    logic [1:0]            ip_sw_q, ip_sw_d;
    logic [NUM_HW_INT-1:0] ip_hw_q;
    logic                  flush_q, flush_d;
    logic [31:0]           new_pc_q, new_pc_d;

    logic                  exc_commit, eret_commit, mtc0_en;
    logic [31:0]           count, compare;
    logic                  ti;
    logic [5:0]            hw_ext;
    logic [7:0]            ip;
    logic [31:0]           cause;

    // Commit priority: exception, then ERET, then MTC0
    assign exc_commit  = exc_valid_i & mem_valid_i;
    assign eret_commit = eret_i & ~exc_commit;
    assign mtc0_en     = we_i & ~exc_commit & ~eret_commit;

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .count_we_i   (mtc0_en && (waddr_i == CP0_REG_COUNT)),
        .compare_we_i (mtc0_en && (waddr_i == CP0_REG_COMPARE)),
        .wdata_i      (wdata_i),
        .count_o      (count),
        .compare_o    (compare),
        .ti_o         (ti)
    );

    // Assemble Cause; the top hardware line shares IP[7] with the timer
    always_comb begin
        hw_ext = '0;
        hw_ext[NUM_HW_INT-1:0] = ip_hw_q;
        ip     = {hw_ext[5] | ti, hw_ext[4:0], ip_sw_q};
        cause  = {bd_q, ti, 14'd0, ip, 1'b0, exccode_q, 2'b00};
    end

    // Commit and MTC0 next-state; EPC/BD frozen while already at exception level
    always_comb begin
        status_d   = status_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        ip_sw_d    = ip_sw_q;
        flush_d    = 1'b0;
        new_pc_d   = new_pc_q;
        if (exc_commit) begin
            if (!status_q[STATUS_EXL]) begin
                epc_d = in_ds_i ? (pc_i - 32'd4) : pc_i;
                bd_d  = in_ds_i;
            end
            status_d[STATUS_EXL] = 1'b1;
            exccode_d = exc_code_i;
            if (is_addr_exc(exc_code_i)) begin
                badvaddr_d = badvaddr_i;
            end
            flush_d  = 1'b1;
            new_pc_d = EXC_VECTOR;
        end else if (eret_commit) begin
            status_d[STATUS_EXL] = 1'b0;
            flush_d  = 1'b1;
            new_pc_d = epc_q;
        end else if (mtc0_en) begin
            case (waddr_i)
                CP0_REG_STATUS: status_d = (STATUS_RST & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
                CP0_REG_CAUSE:  ip_sw_d  = wdata_i[CAUSE_IP_LO+1:CAUSE_IP_LO];
                CP0_REG_EPC:    epc_d    = wdata_i;
                default:        ;
            endcase
        end
    end

    // CP0 register state; hardware interrupt lines sampled every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= STATUS_RST;
            epc_q      <= '0;
            badvaddr_q <= '0;
            bd_q       <= 1'b0;
            exccode_q  <= '0;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
            flush_q    <= 1'b0;
            new_pc_q   <= '0;
        end else begin
            status_q   <= status_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            bd_q       <= bd_d;
            exccode_q  <= exccode_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= int_i;
            flush_q    <= flush_d;
            new_pc_q   <= new_pc_d;
        end
    end

    // MFC0 read mux, showing state before this cycle's write
    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            CP0_REG_BADVADDR: rdata_o = badvaddr_q;
            CP0_REG_COUNT:    rdata_o = count;
            CP0_REG_COMPARE:  rdata_o = compare;
            CP0_REG_STATUS:   rdata_o = status_q;
            CP0_REG_CAUSE:    rdata_o = cause;
            CP0_REG_EPC:      rdata_o = epc_q;
            CP0_REG_PRID:     rdata_o = PRID_VAL;
            CP0_REG_CONFIG:   rdata_o = CONFIG_VAL;
            default:          rdata_o = '0;
        endcase
    end

    assign int_req_o   = status_q[STATUS_IE] & ~status_q[STATUS_EXL]
                       & |(ip & status_q[STATUS_IM_HI:STATUS_IM_LO]);
    assign flush_o     = flush_q;
    assign new_pc_o    = new_pc_q;
    assign status_o    = status_q;
    assign cause_o     = cause;
    assign epc_o       = epc_q;
    assign timer_int_o = ti;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl: register-map table plus timer, interrupt,
// exception and ERET sequences.
module tb_cp0_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic [5:0]  int_i;
    logic        exc_valid_i;
    logic [4:0]  exc_code_i;
    logic        eret_i;
    logic [31:0] pc_i;
    logic        in_ds_i;
    logic [31:0] badvaddr_i;
    logic        mem_valid_i;
    logic        int_req_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        timer_int_o;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    cp0_ctrl #(
        .NUM_HW_INT (6),
        .COUNT_DIV  (2),
        .PRID_VAL   (32'h0000_4220),
        .CONFIG_VAL (32'h0000_8000),
        .STATUS_RST (32'h0040_FF00),
        .EXC_VECTOR (32'hBFC0_0380)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .raddr_i     (raddr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .int_i       (int_i),
        .exc_valid_i (exc_valid_i),
        .exc_code_i  (exc_code_i),
        .eret_i      (eret_i),
        .pc_i        (pc_i),
        .in_ds_i     (in_ds_i),
        .badvaddr_i  (badvaddr_i),
        .mem_valid_i (mem_valid_i),
        .int_req_o   (int_req_o),
        .flush_o     (flush_o),
        .new_pc_o    (new_pc_o),
        .status_o    (status_o),
        .cause_o     (cause_o),
        .epc_o       (epc_o),
        .timer_int_o (timer_int_o)
    );

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        we_i = 1'b0; waddr_i = '0; wdata_i = '0;
        exc_valid_i = 1'b0; exc_code_i = '0; eret_i = 1'b0;
        pc_i = '0; in_ds_i = 1'b0; badvaddr_i = '0; mem_valid_i = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
    endtask

    task automatic raise(input logic [4:0] code, input logic [31:0] pc, input logic ds);
        exc_valid_i = 1'b1; mem_valid_i = 1'b1; exc_code_i = code; pc_i = pc; in_ds_i = ds;
    endtask

    initial begin
        rst = 1'b1; raddr_i = '0; int_i = '0;
        idle();
        vecs[0]  = '{1'b1, 5'd11, 32'hFFFF_FFFF, 5'd12, 32'h0040_FF00, 1'b0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,         5'd15, 32'h0000_4220, 1'b0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,         5'd16, 32'h0000_8000, 1'b0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,         5'd3,  32'h0,         1'b0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,         5'd11, 32'hFFFF_FFFF, 1'b0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,         5'd13, 32'h0,         1'b0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,         5'd14, 32'h0,         1'b0};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,         5'd8,  32'h0,         1'b0};
        vecs[8]  = '{1'b1, 5'd12, 32'hFFFF_FFFF, 5'd12, 32'h0040_FF00, 1'b0};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,         5'd12, 32'h0040_FF03, 1'b0};
        vecs[10] = '{1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0,         1'b0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,         5'd13, 32'h0000_0300, 1'b0};
        vecs[12] = '{1'b1, 5'd12, 32'h0000_0301, 5'd12, 32'h0040_FF03, 1'b0};
        vecs[13] = '{1'b0, 5'd0,  32'h0,         5'd12, 32'h0000_0301, 1'b1};
        vecs[14] = '{1'b1, 5'd12, 32'h0000_0201, 5'd13, 32'h0000_0300, 1'b1};
        vecs[15] = '{1'b0, 5'd0,  32'h0,         5'd12, 32'h0000_0201, 1'b1};
        vecs[16] = '{1'b1, 5'd12, 32'h0000_0200, 5'd12, 32'h0000_0201, 1'b1};
        vecs[17] = '{1'b0, 5'd0,  32'h0,         5'd12, 32'h0000_0200, 1'b0};
        vecs[18] = '{1'b1, 5'd13, 32'h0,         5'd13, 32'h0000_0300, 1'b0};
        vecs[19] = '{1'b0, 5'd0,  32'h0,         5'd13, 32'h0,         1'b0};
        vecs[20] = '{1'b1, 5'd15, 32'h1234_5678, 5'd14, 32'h0,         1'b0};
        vecs[21] = '{1'b0, 5'd0,  32'h0,         5'd15, 32'h0000_4220, 1'b0};
        vecs[22] = '{1'b1, 5'd14, 32'hDEAD_BEEF, 5'd8,  32'h0,         1'b0};
        vecs[23] = '{1'b0, 5'd0,  32'h0,         5'd14, 32'hDEAD_BEEF, 1'b0};
        vecs[24] = '{1'b1, 5'd8,  32'h0000_5555, 5'd16, 32'h0000_8000, 1'b0};
        vecs[25] = '{1'b0, 5'd0,  32'h0,         5'd8,  32'h0,         1'b0};
        vecs[26] = '{1'b0, 5'd0,  32'h0,         5'd31, 32'h0,         1'b0};

        // Reset state
        tick(); tick(); #1;
        chk("rst_status", status_o, 32'h0040_FF00);
        chk("rst_cause", cause_o, 32'h0);
        chk("rst_epc", epc_o, 32'h0);
        chk("rst_flush", {31'd0, flush_o}, 32'd0);
        chk("rst_newpc", new_pc_o, 32'h0);
        chk("rst_ti", {31'd0, timer_int_o}, 32'd0);
        chk("rst_irq", {31'd0, int_req_o}, 32'd0);
        rst = 1'b0;

        // Register map table
        for (int i = 0; i < 27; i++) begin
            we_i = vecs[i].we; waddr_i = vecs[i].waddr; wdata_i = vecs[i].wdata;
            raddr_i = vecs[i].raddr;
            #1;
            chk($sformatf("vec%0d_rdata", i), rdata_o, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_irq", i), {31'd0, int_req_o}, {31'd0, vecs[i].exp_irq});
            tick();
        end
        idle();

        // Timer: Count=0, Compare=5, TI on the increment with Count==5
        mtc0(5'd9, 32'd0); tick();
        mtc0(5'd11, 32'd5); tick();
        idle(); raddr_i = 5'd9;
        for (int k = 1; k <= 12; k++) begin
            tick(); #1;
            chk($sformatf("count_k%0d", k), rdata_o, 32'((k + 1) / 2));
            chk($sformatf("ti_k%0d", k), {31'd0, timer_int_o}, {31'd0, (k >= 11)});
        end
        raddr_i = 5'd13; #1;
        chk("cause_ti", rdata_o, 32'h4000_8000);
        mtc0(5'd11, 32'hFFFF_FFFF); tick(); idle(); #1;
        chk("ti_cleared", {31'd0, timer_int_o}, 32'd0);
        chk("cause_after_clr", rdata_o, 32'h0);

        // Interrupt masking
        mtc0(5'd12, 32'h0000_0401); tick();
        idle(); int_i = 6'b000001; #1;
        chk("irq_before_sample", {31'd0, int_req_o}, 32'd0);
        tick(); #1;
        chk("irq_on", {31'd0, int_req_o}, 32'd1);
        chk("cause_ip2", cause_o, 32'h0000_0400);
        mtc0(5'd12, 32'h0000_0403); tick(); idle(); #1;
        chk("irq_exl_mask", {31'd0, int_req_o}, 32'd0);
        tick(); #1;
        chk("irq_exl_mask2", {31'd0, int_req_o}, 32'd0);
        int_i = '0; mtc0(5'd12, 32'h0); tick(); idle(); tick();

        // Exception in delay slot
        raise(5'd12, 32'h8000_1004, 1'b1); tick(); idle(); #1;
        chk("exc_flush", {31'd0, flush_o}, 32'd1);
        chk("exc_newpc", new_pc_o, 32'hBFC0_0380);
        chk("exc_epc", epc_o, 32'h8000_1000);
        chk("exc_cause", cause_o, 32'h8000_0030);
        chk("exc_status", status_o, 32'h0000_0002);
        tick(); #1;
        chk("exc_flush_1cyc", {31'd0, flush_o}, 32'd0);
        raise(5'd10, 32'h8000_5000, 1'b0); tick(); idle(); #1;
        chk("exc2_epc_kept", epc_o, 32'h8000_1000);
        chk("exc2_cause", cause_o, 32'h8000_0028);
        chk("exc2_flush", {31'd0, flush_o}, 32'd1);
        tick();

        // AdEL with a same-cycle MTC0 to EPC
        mtc0(5'd12, 32'h0); tick(); idle();
        raise(5'd4, 32'h8000_3000, 1'b0); badvaddr_i = 32'h3;
        mtc0(5'd14, 32'h1111_1111); tick(); idle(); raddr_i = 5'd8; #1;
        chk("adel_badvaddr", rdata_o, 32'h3);
        chk("adel_epc", epc_o, 32'h8000_3000);
        chk("adel_cause", cause_o, 32'h0000_0010);
        chk("adel_flush", {31'd0, flush_o}, 32'd1);
        chk("adel_newpc", new_pc_o, 32'hBFC0_0380);
        tick();

        // ERET with a dropped same-cycle MTC0, then reset during the flush
        mtc0(5'd14, 32'h8000_2000); tick(); idle();
        eret_i = 1'b1; mtc0(5'd12, 32'hFFFF_FFFF); tick(); idle(); #1;
        chk("eret_flush", {31'd0, flush_o}, 32'd1);
        chk("eret_newpc", new_pc_o, 32'h8000_2000);
        chk("eret_status", status_o, 32'h0);
        rst = 1'b1; tick(); #1;
        chk("rst_mid_flush", {31'd0, flush_o}, 32'd0);
        chk("rst_mid_newpc", new_pc_o, 32'h0);
        chk("rst_mid_status", status_o, 32'h0040_FF00);
        chk("rst_mid_epc", epc_o, 32'h0);
        rst = 1'b0;

        // Exception and ERET together: exception wins
        raise(5'd8, 32'h8000_4000, 1'b0); eret_i = 1'b1; tick(); idle(); #1;
        chk("both_newpc", new_pc_o, 32'hBFC0_0380);
        chk("both_status", status_o, 32'h0040_FF02);
        chk("both_epc", epc_o, 32'h8000_4000);
        chk("both_cause", cause_o, 32'h0000_0020);

        // Exception on a bubble is ignored
        exc_valid_i = 1'b1; exc_code_i = 5'd10; mem_valid_i = 1'b0; tick(); idle(); #1;
        chk("bubble_flush", {31'd0, flush_o}, 32'd0);
        chk("bubble_epc", epc_o, 32'h8000_4000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cp0_ctrl.md
Name: cp0_ctrl

Overview:
Parametrised CP0 register file and exception controller for the five-stage MIPS pipeline. It sits beside the MEM stage and holds Count, Compare, Status, Cause, EPC, BadVAddr, PRId and Config. It detects and prioritises interrupts, commits exceptions and ERET atomically, and returns a flush request with the redirect PC to the pipeline controller. It adds a prescaled Count, parametrised hardware-interrupt width, interrupt masking, and EPC/BD update suppression while EXL is set.

Parameters:
NUM_HW_INT, 6, number of external hardware interrupt lines (1..6); mapped to Cause.IP[2+NUM_HW_INT-1:2]; unused IP bits read 0
COUNT_DIV, 2, Count increments once every COUNT_DIV clocks (1..16)
PRID_VAL, 32'h00004220, read-only PRId value
CONFIG_VAL, 32'h00008000, read-only Config value
STATUS_RST, 32'h0040FF00, Status reset value (BEV=1, IM all set, EXL=0, IE=0)
EXC_VECTOR, 32'hBFC00380, exception redirect address

Ports:
clk  in  1  clock
rst  in  1  reset (synchronous, active-high)
we_i  in  1  MTC0 write enable
waddr_i  in  5  MTC0 register number
raddr_i  in  5  MFC0 register number
wdata_i  in  32  MTC0 data
rdata_o  out  32  MFC0 read data (combinational)
int_i  in  NUM_HW_INT  external interrupt lines, level-sensitive
exc_valid_i  in  1  MEM-stage instruction raises an exception
exc_code_i  in  5  ExcCode (Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12, Tr=13)
eret_i  in  1  MEM-stage instruction is ERET
pc_i  in  32  MEM-stage instruction PC
in_ds_i  in  1  MEM-stage instruction is in a delay slot
badvaddr_i  in  32  faulting address for AdEL/AdES
mem_valid_i  in  1  MEM stage holds a real instruction (not a bubble)
int_req_o  out  1  qualified interrupt pending (the pipeline injects ExcCode 0 on the next valid instruction)
flush_o  out  1  one-cycle pulse: flush pipeline and redirect
new_pc_o  out  32  redirect target, valid when flush_o=1
status_o, cause_o, epc_o  out  32 each  direct register views for the hazard/forward logic
timer_int_o  out  1  Cause.TI

Behaviour:
- Reset values:
  - Count=0, Compare=0, Status=STATUS_RST, Cause=0, EPC=0, BadVAddr=0, prescaler=0.
  - flush_o=0, new_pc_o=0, timer_int_o=0, int_req_o=0.
- Register map: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId, 16 Config. Any other address reads 0.
- Writable fields:
  - Count, Compare, EPC: all bits.
  - Status: bits 22, 15:8, 1, 0; all other bits are fixed at their STATUS_RST value.
  - Cause: IP[1:0] (bits 9:8) only.
  - BadVAddr, PRId and Config are read-only.
- Prescaler:
  - Counts 0..COUNT_DIV-1 and wraps.
  - Count increments modulo 2^32 on the wrap.
  - A Count write loads wdata_i and clears the prescaler.
- Timer:
  - When Count==Compare on an increment cycle, Cause.TI (bit 30) is set. It is sticky.
  - A Compare write clears TI. If the write and the match occur in the same cycle, the write wins and TI stays 0.
  - Cause.IP[7] = TI.
- Hardware interrupts: Cause.IP[2+NUM_HW_INT-1:2] is registered from int_i every cycle (one-cycle latency); it is not writable.
- Interrupt request: int_req_o = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]). Combinational from the registers.
- Commit priority within a cycle, highest first: exception (exc_valid_i & mem_valid_i), then ERET, then MTC0.
  - A committed exception or ERET suppresses a same-cycle MTC0 write entirely.
- Exception commit:
  - If EXL=0: EPC = in_ds_i ? pc_i-4 : pc_i, and Cause.BD = in_ds_i.
  - If EXL=1: EPC and BD are unchanged.
  - Always: Cause.ExcCode = exc_code_i and EXL=1.
  - BadVAddr is loaded only for codes 4 and 5.
  - Next cycle: flush_o=1 and new_pc_o=EXC_VECTOR.
- ERET commit: EXL=0. Next cycle: flush_o=1 and new_pc_o = the EPC value before the commit.
- flush_o is high for exactly one cycle per commit. An exception and ERET together: the exception wins.
- The Count increment, the timer compare and IP sampling continue during a commit cycle.
- Read data:
  - rdata_o reflects the register state before the current cycle's write (no internal bypass).
  - MEM→EX forwarding is the pipeline's job.
- Reset mid-operation: a pending flush_o is cancelled; all state returns to reset values on the next edge.

Decomposition:
- Shared package cp0_pkg holds:
  - register-address constants (CP0_REG_*);
  - ExcCode constants;
  - Status/Cause bit-position constants (IE=0, EXL=1, IM=15:8, BEV=22, BD=31, TI=30, IP=15:8, EXC=6:2);
  - writable-mask constants for Status and Cause.
- One sub-module, cp0_timer: the prescaler, Count, Compare and TI logic, with a write/clear interface.

Test Plan:
- Reset, then read all map addresses → Status=0x0040FF00, PRId=0x00004220, Config=0x00008000; addr 3 reads 0.
- COUNT_DIV=2, write Compare=5 at Count=0 → TI=1 in the cycle after Count reaches 5 (about 10 clocks); a Compare write then clears TI.
- Status=0x0000_0401 (IE=1, IM[2]=1), int_i[0]=1 → int_req_o=1 two cycles later. The same stimulus with EXL=1 → int_req_o stays 0.
- Exception code 12 at pc 0x80001004 with in_ds_i=1 → EPC=0x80001000, BD=1, ExcCode=12, EXL=1, then flush_o pulse with new_pc_o=0xBFC00380. A second exception while EXL=1 → EPC unchanged.
- AdEL with badvaddr 0x00000003 and a same-cycle MTC0 to EPC → BadVAddr=3, EPC comes from the exception path and the MTC0 is dropped.
- ERET with EPC=0x80002000 → EXL=0, flush_o=1, new_pc_o=0x80002000. Reset asserted in that flush cycle → flush_o=0 the next cycle.
